fpu_cvt_arb: RTL and testbench

FPU_CVT_ARB -- requirements
Module: fpu_cvt_arb

---
 rtl/fpu_cvt_arb.sv | 179 +++++++++++++++++
 tb/tb_fpu_cvt_arb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_cvt_arb.sv
// ============================================================================
//  Module      : fpu_cvt_arb
//  Description : Two-requester round-robin front end for a fixed-latency
//                pipelined conversion unit. Operands are granted with
//                credit-based flow control and tagged through a latency-matched
//                pipe. Results are steered into a 2-entry FIFO per requester.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fpu_cvt_arb #(
  parameter int LAT = 6,   // conversion unit latency in clock edges (1..15)
  parameter int DW  = 32   // operand / result width
) (
  input  logic          clk,
  input  logic          rst_n,
  // requester 0
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_data,
  input  logic          rsp0_ready,
  // requester 1
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_data,
  input  logic          rsp1_ready,
  // conversion unit
  output logic [DW-1:0] fu_src,
  input  logic [DW-1:0] fu_res,
  // status
  output logic          busy
);

  localparam int c_NUM_REQ = 2;

  // Per-requester views of the flat ports
  logic [c_NUM_REQ-1:0] w_req_valid;
  logic [c_NUM_REQ-1:0] w_rsp_ready;
  logic [c_NUM_REQ-1:0] w_credit;
  logic [c_NUM_REQ-1:0] w_elig;
  logic [c_NUM_REQ-1:0] w_grant;
  logic [c_NUM_REQ-1:0] w_push;
  logic [c_NUM_REQ-1:0] w_pop;
  logic [c_NUM_REQ-1:0] w_rsp_valid;
  logic [DW-1:0]        w_rsp_data [c_NUM_REQ];

  logic                 w_hs;
  logic                 w_hs_id;
  logic                 w_cap_vld;
  logic                 w_cap_id;

  // Round-robin pointer: requester favoured when both are eligible
  logic                 r_prio;

  // Tag pipe: one {valid,id} slot per conversion unit stage
  logic [LAT-1:0]       r_tag_vld;
  logic [LAT-1:0]       r_tag_id;

  assign w_req_valid = {req1_valid, req0_valid};
  assign w_rsp_ready = {rsp1_ready, rsp0_ready};

  // Eligibility and round-robin grant; ready is purely combinational
  assign w_elig     = w_req_valid & w_credit;
  assign w_grant[0] = w_elig[0] & (~w_elig[1] | ~r_prio);
  assign w_grant[1] = w_elig[1] & (~w_elig[0] |  r_prio);
  assign w_hs       = |w_grant;
  assign w_hs_id    = w_grant[1];

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];

  // The oldest tag lines up with the unit result on this edge
  assign w_cap_vld = r_tag_vld[LAT-1];
  assign w_cap_id  = r_tag_id[LAT-1];

  // Pointer moves to the other requester after every grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (w_hs) begin
      r_prio <= ~w_hs_id;
    end
  end

  // Operand register feeding the conversion unit; holds when nothing issues
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_src <= '0;
    end else if (w_hs) begin
      fu_src <= w_hs_id ? req1_data : req0_data;
    end
  end

  // Tag pipe shifts every edge; bubbles carry valid=0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      for (int k = LAT - 1; k > 0; k--) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
      end
      r_tag_vld[0] <= w_hs;
      r_tag_id[0]  <= w_hs_id;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < c_NUM_REQ; gi++) begin : g_req
      logic [DW-1:0] r_mem [2];
      logic          r_wptr;
      logic          r_rptr;
      logic [1:0]    r_fcnt;
      logic [1:0]    r_cnt;

      // Outstanding count covers in-flight plus buffered results, so a
      // full credit also bounds the FIFO to its two entries.
      assign w_credit[gi]    = (r_cnt < 2'd2);
      assign w_push[gi]      = w_cap_vld & (w_cap_id == 1'(gi));
      assign w_rsp_valid[gi] = (r_fcnt != 2'd0);
      assign w_pop[gi]       = w_rsp_valid[gi] & w_rsp_ready[gi];
      assign w_rsp_data[gi]  = r_mem[r_rptr];

      // Result FIFO storage and pointers; push and pop may share an edge
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mem[0] <= '0;
          r_mem[1] <= '0;
          r_wptr   <= 1'b0;
          r_rptr   <= 1'b0;
          r_fcnt   <= 2'd0;
        end else begin
          if (w_push[gi]) begin
            r_mem[r_wptr] <= fu_res;
            r_wptr        <= ~r_wptr;
          end
          if (w_pop[gi]) begin
            r_rptr <= ~r_rptr;
          end
          case ({w_push[gi], w_pop[gi]})
            2'b10:   r_fcnt <= r_fcnt + 2'd1;
            2'b01:   r_fcnt <= r_fcnt - 2'd1;
            default: r_fcnt <= r_fcnt;
          endcase
        end
      end

      // Issued-but-not-consumed counter driving the credit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= 2'd0;
        end else begin
          case ({w_grant[gi], w_pop[gi]})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
          endcase
        end
      end
    end
  endgenerate

  assign rsp0_valid = w_rsp_valid[0];
  assign rsp1_valid = w_rsp_valid[1];
  assign rsp0_data  = w_rsp_data[0];
  assign rsp1_data  = w_rsp_data[1];

  assign busy = (|r_tag_vld) | (|w_rsp_valid);

endmodule

`default_nettype wire

// File: tb/tb_fpu_cvt_arb.sv
// ============================================================================
//  Module      : tb_fpu_cvt_arb
//  Description : Self-checking bench for fpu_cvt_arb: vector table, directed
//                corner sequences and randomized traffic against a queue-based
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fpu_cvt_arb;

  localparam int LAT = 6;
  localparam int DW  = 32;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic          rsp0_ready, rsp1_ready;
  logic [DW-1:0] fu_src;
  logic [DW-1:0] fu_res;
  logic          busy;

  fpu_cvt_arb #(.LAT(LAT), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
    .fu_src(fu_src), .fu_res(fu_res), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in conversion function
  function automatic logic [31:0] fn(input logic [31:0] x);
    return (x ^ 32'hA5A5_5A5A) + 32'd7;
  endfunction

  // Conversion unit model: fu_src is its first stage, LAT-1 more stages here
  logic [31:0] p [LAT-1];
  always @(posedge clk) begin
    p[0] <= fu_src;
    for (int k = 1; k < LAT - 1; k++) p[k] <= p[k-1];
  end
  assign fu_res = fn(p[LAT-2]);

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] val;
    int          rdy;   // edge number after which the result is visible
  } pend_t;

  pend_t q0[$];
  pend_t q1[$];
  bit    m_prio;
  int    edge_n;

  int checks;
  int failures;

  // last sampled DUT values
  logic        s_r0, s_r1, s_rv0, s_rv1, s_hs0, s_hs1;
  logic [31:0] s_rd0, s_rd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // One clock cycle: drive, compare against model, advance model on the edge
  task automatic step(input logic v0, input logic v1, input logic [31:0] d0,
                      input logic [31:0] d1, input logic rr0, input logic rr1);
    logic e0, e1, g0, g1, ev0, ev1;
    @(negedge clk);
    req0_valid = v0; req1_valid = v1;
    req0_data  = d0; req1_data  = d1;
    rsp0_ready = rr0; rsp1_ready = rr1;
    #1;
    e0 = v0 && (q0.size() < 2);
    e1 = v1 && (q1.size() < 2);
    if (e0 && e1) begin
      g0 = !m_prio; g1 = m_prio;
    end else begin
      g0 = e0; g1 = e1;
    end
    ev0 = (q0.size() > 0) && (q0[0].rdy <= edge_n);
    ev1 = (q1.size() > 0) && (q1[0].rdy <= edge_n);
    s_r0 = req0_ready; s_r1 = req1_ready;
    s_rv0 = rsp0_valid; s_rv1 = rsp1_valid;
    s_rd0 = rsp0_data;  s_rd1 = rsp1_data;
    s_hs0 = req0_ready & v0; s_hs1 = req1_ready & v1;
    check1("req0_ready", req0_ready, g0);
    check1("req1_ready", req1_ready, g1);
    check1("rsp0_valid", rsp0_valid, ev0);
    check1("rsp1_valid", rsp1_valid, ev1);
    if (ev0) check("rsp0_data", rsp0_data, q0[0].val);
    if (ev1) check("rsp1_data", rsp1_data, q1[0].val);
    check1("busy", busy, (q0.size() + q1.size()) > 0);
    @(posedge clk);
    edge_n++;
    if (ev0 && rr0) void'(q0.pop_front());
    if (ev1 && rr1) void'(q1.pop_front());
    if (g0) begin q0.push_back('{val: fn(d0), rdy: edge_n + LAT}); m_prio = 1'b1; end
    if (g1) begin q1.push_back('{val: fn(d1), rdy: edge_n + LAT}); m_prio = 1'b0; end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
  endtask

  typedef struct {
    logic        v0, v1;
    logic [31:0] d0, d1;
    logic        er0, er1;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, n0, n1, nr;
    logic [31:0] fsrc;

    checks = 0; failures = 0; edge_n = 0; m_prio = 1'b0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Table: arbitration and credit from a clean reset (prio=0, no credit used)
    tbl[0] = '{1'b1, 1'b0, 32'h0000_1111, 32'h0000_2222, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 32'h0000_3333, 32'h0000_4444, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_5555, 32'h0000_6666, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 32'h0000_7777, 32'h0000_8888, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 32'h0000_9999, 32'h0000_AAAA, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 32'h0000_BBBB, 32'h0000_CCCC, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 32'h0000_DDDD, 32'h0000_EEEE, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check1("rst_req0_ready", req0_ready, 1'b0);
    check1("rst_rsp0_valid", rsp0_valid, 1'b0);
    check1("rst_rsp1_valid", rsp1_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check("rst_fu_src", fu_src, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Vector table; first entry exercises the first edge after reset release
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].v0, tbl[i].v1, tbl[i].d0, tbl[i].d1, 1'b1, 1'b1);
      check1("tbl_ready0", s_r0, tbl[i].er0);
      check1("tbl_ready1", s_r1, tbl[i].er1);
    end
    idle(16);

    // Single operation latency
    step(1'b1, 1'b0, 32'h40C9_9999, 32'h0, 1'b1, 1'b1);
    #1;
    check("single_fu_src", fu_src, 32'h40C9_9999);
    first = -1;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      if (s_rv0 && first < 0) begin
        first = k;
        check("single_rsp_data", s_rd0, fn(32'h40C9_9999));
      end
    end
    check("single_latency", first, 32'd7);
    idle(4);

    // Credit: requester 0 stalls its responses
    n0 = 0; n1 = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, $urandom, $urandom, 1'b0, 1'b1);
      n0 += int'(s_hs0); n1 += int'(s_hs1);
    end
    check("credit_req0_grants", n0, 32'd2);
    check1("credit_req1_served", n1 > 2, 1'b1);
    n0 = 0;
    step(1'b1, 1'b1, $urandom, $urandom, 1'b1, 1'b1);
    n0 += int'(s_hs0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, $urandom, $urandom, 1'b0, 1'b1);
      n0 += int'(s_hs0);
    end
    check("credit_after_pop", n0, 32'd1);
    idle(20);

    // Push and pop on the same FIFO at the same edge
    step(1'b1, 1'b0, 32'hCAFE_0001, 32'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'hCAFE_0002, 32'h0, 1'b1, 1'b1);
    nr = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      nr += int'(s_rv0);
    end
    check("pushpop_rsp_count", nr, 32'd2);

    // Idle: operand register and pointer hold
    fsrc = fu_src;
    idle(20);
    check("idle_fu_src", fu_src, fsrc);
    check1("idle_busy", busy, 1'b0);
    step(1'b1, 1'b1, 32'h1234_0000, 32'h5678_0000, 1'b1, 1'b1);
    check1("idle_prio_r0", s_r0, 1'b0);
    check1("idle_prio_r1", s_r1, 1'b1);
    idle(12);

    // Reset with three operations in flight
    step(1'b1, 1'b0, 32'h0BAD_0001, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h0, 32'h0BAD_0002, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'h0BAD_0003, 32'h0, 1'b1, 1'b1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check1("midrst_rsp0_valid", rsp0_valid, 1'b0);
    check1("midrst_rsp1_valid", rsp1_valid, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    check("midrst_fu_src", fu_src, 32'h0);
    q0.delete(); q1.delete(); m_prio = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    nr = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      nr += int'(s_rv0) + int'(s_rv1);
    end
    check("midrst_no_rsp", nr, 32'd0);
    step(1'b1, 1'b1, 32'h7777_0000, 32'h8888_0000, 1'b1, 1'b1);
    check1("midrst_prio_reset", s_r0, 1'b1);
    idle(12);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, $urandom, $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
    end
    idle(20);
    check1("final_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
